// File: rtl/kch_sequencer.sv
// kch_sequencer: round controller for the known-CH tracker.
// Clears the tracker on a heartbeat, buffers CH advertisements in a small
// FIFO and replays them as single-cycle tracker enables separated by a settle
// window, then latches the tracker's chosen CH and hop count.
// Optional feature: define KCH_TIMEOUT_EN to build the COLLECT inactivity
// timeout (round ends early with ch_timeout after TIMEOUT idle cycles).
module kch_sequencer #(
    parameter int WORD_WIDTH    = 16,
    parameter int FIFO_DEPTH    = 4,
    parameter int CLR_CYCLES    = 2,
    parameter int SETTLE_CYCLES = 2,
    parameter int TIMEOUT       = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hb_start,
    input  logic [WORD_WIDTH-1:0] hb_chlimit,
    input  logic                  adv_valid,
    output logic                  adv_ready,
    input  logic [WORD_WIDTH-1:0] adv_id,
    input  logic [WORD_WIDTH-1:0] adv_hops,
    input  logic [WORD_WIDTH-1:0] adv_qvalue,
    output logic                  kch_hb_reset,
    output logic                  kch_en,
    output logic [WORD_WIDTH-1:0] kch_id,
    output logic [WORD_WIDTH-1:0] kch_hops,
    output logic [WORD_WIDTH-1:0] kch_qvalue,
    input  logic [WORD_WIDTH-1:0] kch_chosen,
    input  logic [WORD_WIDTH-1:0] kch_hopsfrom,
    output logic [WORD_WIDTH-1:0] chosen_ch,
    output logic [WORD_WIDTH-1:0] hops_from_ch,
    output logic                  ch_done,
    output logic                  ch_timeout,
    output logic [WORD_WIDTH-1:0] ch_count,
    output logic                  busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 3 * WORD_WIDTH;
    localparam int CW = $clog2(CLR_CYCLES + 1);
    localparam int SW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_COLLECT, S_DONE} state_t;

    state_t                r_state, w_state_next;
    logic [EW-1:0]         r_fifo_mem [FIFO_DEPTH];
    logic [AW:0]           r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]         r_clr_cnt;
    logic [SW-1:0]         r_settle_cnt;
    logic [WORD_WIDTH-1:0] r_limit, r_ch_count;
    logic                  r_kch_en;
    logic [WORD_WIDTH-1:0] r_kch_id, r_kch_hops, r_kch_qvalue;
    logic [WORD_WIDTH-1:0] r_chosen_ch, r_hops_from_ch;

    logic                  w_fifo_empty, w_fifo_full, w_adv_ready;
    logic                  w_push, w_pop, w_timeout_cond, w_timeout_hit;
    logic [EW-1:0]         w_head;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
    assign w_fifo_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                          (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_adv_ready  = ((r_state == S_CLEAR) || (r_state == S_COLLECT)) && !w_fifo_full;
    assign w_push       = adv_valid && w_adv_ready;
    // A heartbeat aborts the round, so it suppresses any pop in that cycle.
    assign w_pop        = (r_state == S_COLLECT) && !w_fifo_empty && (r_settle_cnt == '0) &&
                          (r_ch_count < r_limit) && !hb_start;
    assign w_head       = r_fifo_mem[r_rd_ptr[AW-1:0]];

    // Next-state logic; a heartbeat in any state restarts the round.
    always_comb begin
        w_state_next  = r_state;
        w_timeout_hit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (hb_start) w_state_next = S_CLEAR;
            end
            S_CLEAR: begin
                if (hb_start)
                    w_state_next = S_CLEAR;
                else if (r_clr_cnt == '0)
                    w_state_next = (r_limit == '0) ? S_DONE : S_COLLECT;
            end
            S_COLLECT: begin
                if (hb_start) begin
                    w_state_next = S_CLEAR;
                end else if ((r_ch_count == r_limit) && (r_settle_cnt == '0)) begin
                    w_state_next = S_DONE;
                end else if (w_timeout_cond) begin
                    w_state_next  = S_DONE;
                    w_timeout_hit = 1'b1;
                end
            end
            S_DONE: begin
                w_state_next = hb_start ? S_CLEAR : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State, FIFO pointers, round counters and registered tracker/result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_clr_cnt      <= '0;
            r_settle_cnt   <= '0;
            r_limit        <= '0;
            r_ch_count     <= '0;
            r_kch_en       <= 1'b0;
            r_kch_id       <= '0;
            r_kch_hops     <= '1;
            r_kch_qvalue   <= '0;
            r_chosen_ch    <= '0;
            r_hops_from_ch <= '1;
        end else begin
            r_state  <= w_state_next;
            r_kch_en <= w_pop;
            if (hb_start) begin
                // New round: flush wins over any push on the same edge.
                r_wr_ptr     <= '0;
                r_rd_ptr     <= '0;
                r_ch_count   <= '0;
                r_limit      <= hb_chlimit;
                r_clr_cnt    <= CW'(CLR_CYCLES - 1);
                r_settle_cnt <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                if ((r_state == S_CLEAR) && (r_clr_cnt != '0))
                    r_clr_cnt <= r_clr_cnt - 1'b1;
                if (w_pop) begin
                    r_settle_cnt <= SW'(SETTLE_CYCLES);
                    if (r_ch_count != '1) r_ch_count <= r_ch_count + 1'b1;
                end else if (r_settle_cnt != '0) begin
                    r_settle_cnt <= r_settle_cnt - 1'b1;
                end
            end
            if (w_pop) begin
                r_kch_id     <= w_head[EW-1 -: WORD_WIDTH];
                r_kch_hops   <= w_head[2*WORD_WIDTH-1 -: WORD_WIDTH];
                r_kch_qvalue <= w_head[WORD_WIDTH-1:0];
            end
            // Latch on the edge into DONE so the result is valid with ch_done.
            if (w_state_next == S_DONE) begin
                r_chosen_ch    <= kch_chosen;
                r_hops_from_ch <= kch_hopsfrom;
            end
        end
    end

    // Advertisement storage; no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo_mem[r_wr_ptr[AW-1:0]] <= {adv_id, adv_hops, adv_qvalue};
    end

`ifdef KCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_to_cnt;
    logic          r_to_flag;

    // Inactivity counter: runs only in COLLECT, restarted by every pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt  <= '0;
            r_to_flag <= 1'b0;
        end else begin
            r_to_flag <= w_timeout_hit;
            if ((r_state != S_COLLECT) || w_pop)
                r_to_cnt <= '0;
            else if (r_to_cnt != '1)
                r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout_cond = (r_state == S_COLLECT) && (r_to_cnt == TW'(TIMEOUT - 1)) &&
                            (r_ch_count < r_limit) && !w_pop;
    assign ch_timeout     = (r_state == S_DONE) && r_to_flag;
`else
    logic w_unused_timeout;
    assign w_timeout_cond   = 1'b0;
    assign ch_timeout       = 1'b0;
    assign w_unused_timeout = (TIMEOUT > 0) | w_timeout_hit;
`endif

    assign adv_ready    = w_adv_ready;
    assign kch_hb_reset = (r_state == S_CLEAR);
    assign kch_en       = r_kch_en;
    assign kch_id       = r_kch_id;
    assign kch_hops     = r_kch_hops;
    assign kch_qvalue   = r_kch_qvalue;
    assign chosen_ch    = r_chosen_ch;
    assign hops_from_ch = r_hops_from_ch;
    assign ch_done      = (r_state == S_DONE);
    assign ch_count     = r_ch_count;
    assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_kch_sequencer.sv
// Testbench for kch_sequencer: a behavioural tracker drives kch_chosen and
// kch_hopsfrom, and a queue model predicts which advertisements are replayed
// and which CH each round should report.
module tb_kch_sequencer;

    localparam int W      = 16;
    localparam int SETTLE = 2;
    localparam int TMO    = 16;

    typedef struct packed {
        logic [W-1:0] id;
        logic [W-1:0] hops;
        logic [W-1:0] q;
    } adv_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         hb_start;
    logic [W-1:0] hb_chlimit;
    logic         adv_valid;
    logic         adv_ready;
    logic [W-1:0] adv_id, adv_hops, adv_qvalue;
    logic         kch_hb_reset, kch_en;
    logic [W-1:0] kch_id, kch_hops, kch_qvalue;
    logic [W-1:0] kch_chosen, kch_hopsfrom;
    logic [W-1:0] chosen_ch, hops_from_ch;
    logic         ch_done, ch_timeout;
    logic [W-1:0] ch_count;
    logic         busy;

    kch_sequencer #(
        .WORD_WIDTH(W), .FIFO_DEPTH(4), .CLR_CYCLES(2),
        .SETTLE_CYCLES(SETTLE), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .hb_start(hb_start), .hb_chlimit(hb_chlimit),
        .adv_valid(adv_valid), .adv_ready(adv_ready),
        .adv_id(adv_id), .adv_hops(adv_hops), .adv_qvalue(adv_qvalue),
        .kch_hb_reset(kch_hb_reset), .kch_en(kch_en),
        .kch_id(kch_id), .kch_hops(kch_hops), .kch_qvalue(kch_qvalue),
        .kch_chosen(kch_chosen), .kch_hopsfrom(kch_hopsfrom),
        .chosen_ch(chosen_ch), .hops_from_ch(hops_from_ch),
        .ch_done(ch_done), .ch_timeout(ch_timeout), .ch_count(ch_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc = 0, hb_cyc = 0, acc_cyc = 0, last_en_cyc = 0, done_cyc = 0;
    int   en_cnt = 0, clr_len = 0, done_total = 0;
    logic done_seen = 1'b0, done_to = 1'b0, saw_stall = 1'b0, gappy = 1'b0;
    logic [W-1:0] trk_q = '0;
    adv_t offer_q[$];
    adv_t model_q[$];
    adv_t round_pops[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected tracker result: strictly-higher Q wins, starting from the cleared state.
    function automatic adv_t best_of();
        adv_t b;
        b.id = '0; b.hops = '1; b.q = '0;
        foreach (round_pops[i]) if (round_pops[i].q > b.q) b = round_pops[i];
        return b;
    endfunction

    task automatic drive_adv();
        if (offer_q.size() > 0 && (!gappy || $urandom_range(0, 3) != 0)) begin
            adv_valid  = 1'b1;
            adv_id     = offer_q[0].id;
            adv_hops   = offer_q[0].hops;
            adv_qvalue = offer_q[0].q;
        end else begin
            adv_valid = 1'b0;
        end
    endtask

    // One clock: sample pre-edge inputs, advance, update tracker and model, observe outputs.
    task automatic tick();
        logic s_en, s_clr, s_hb, s_val, s_rdy;
        logic [W-1:0] s_id, s_hops, s_q;
        adv_t a, e;
        s_en = kch_en; s_clr = kch_hb_reset; s_id = kch_id; s_hops = kch_hops; s_q = kch_qvalue;
        s_hb = hb_start; s_val = adv_valid; s_rdy = adv_ready;
        if (s_val && !s_rdy) saw_stall = 1'b1;
        @(posedge clk);
        #1;
        if (s_hb) hb_cyc = cyc;
        cyc++;
        if (s_clr) begin
            kch_chosen = '0; kch_hopsfrom = '1; trk_q = '0;
        end else if (s_en && s_q > trk_q) begin
            kch_chosen = s_id; kch_hopsfrom = s_hops; trk_q = s_q;
        end
        if (s_val && s_rdy && offer_q.size() > 0) begin
            a = offer_q.pop_front();
            if (!s_hb) begin
                model_q.push_back(a);
                acc_cyc = cyc;
            end
        end
        if (s_hb) begin
            model_q.delete(); round_pops.delete(); en_cnt = 0; done_seen = 1'b0;
        end
        if (kch_hb_reset) clr_len = s_clr ? clr_len + 1 : 1;
        if (kch_en) begin
            if (model_q.size() == 0) begin
                check_val("pop_unexpected", 32'd1, 32'd0);
            end else begin
                e = model_q.pop_front();
                check_val("pop_id", kch_id, e.id);
                check_val("pop_hops", kch_hops, e.hops);
                check_val("pop_q", kch_qvalue, e.q);
                round_pops.push_back(e);
            end
            if (en_cnt > 0) check_val("pop_spacing", (cyc - last_en_cyc) >= SETTLE + 1, 1);
            en_cnt++;
            last_en_cyc = cyc;
            $display("txn pop cyc=%0d id=%0d hops=%0d q=%0h", cyc, kch_id, kch_hops, kch_qvalue);
        end
        if (ch_done) begin
            done_seen = 1'b1; done_cyc = cyc; done_to = ch_timeout; done_total++;
            $display("txn done cyc=%0d chosen=%0d hops=%0d to=%0b", cyc, chosen_ch, hops_from_ch, ch_timeout);
        end
        if (ch_timeout && !ch_done) check_val("timeout_without_done", 32'd1, 32'd0);
        drive_adv();
    endtask

    task automatic start_round(input logic [W-1:0] lim);
        offer_q.delete();
        adv_valid  = 1'b0;
        done_seen  = 1'b0;
        hb_start   = 1'b1;
        hb_chlimit = lim;
        tick();
        hb_start = 1'b0;
    endtask

    task automatic offer(input logic [W-1:0] id, input logic [W-1:0] hops, input logic [W-1:0] q);
        adv_t a;
        a.id = id; a.hops = hops; a.q = q;
        offer_q.push_back(a);
        drive_adv();
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done_seen; i++) tick();
        check_val("done_within_budget", done_seen, 1);
    endtask

    task automatic wait_pops(input int n, input int budget);
        for (int i = 0; i < budget && en_cnt < n; i++) tick();
        check_val("pops_within_budget", en_cnt >= n, 1);
    endtask

    task automatic check_result(input string tag);
        adv_t b;
        b = best_of();
        check_val({tag, "_chosen"}, chosen_ch, b.id);
        check_val({tag, "_hops"}, hops_from_ch, b.hops);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int   lim, nadv, dones_before;
        logic [W-1:0] prev_chosen;

        rst = 1'b1; hb_start = 1'b0; hb_chlimit = '0; adv_valid = 1'b0;
        adv_id = '0; adv_hops = '0; adv_qvalue = '0;
        kch_chosen = '0; kch_hopsfrom = '1;
        tick(); tick();
        check_val("rst_busy", busy, 0);
        check_val("rst_adv_ready", adv_ready, 0);
        check_val("rst_kch_hops", kch_hops, 16'hFFFF);
        check_val("rst_hops_from_ch", hops_from_ch, 16'hFFFF);
        check_val("rst_ch_done", ch_done, 0);
        check_val("rst_kch_en", kch_en, 0);
        check_val("rst_chosen", chosen_ch, 0);
        check_val("rst_ch_count", ch_count, 0);
        rst = 1'b0;
        tick();

        // Basic three-advertisement round.
        start_round(16'd3);
        offer(16'd23, 16'd2, 16'h3000);
        offer(16'd45, 16'd2, 16'h2000);
        offer(16'd12, 16'd1, 16'h4000);
        wait_done(60);
        check_val("basic_clr_len", clr_len, 2);
        check_val("basic_pops", en_cnt, 3);
        check_val("basic_ch_count", ch_count, 3);
        check_val("basic_chosen", chosen_ch, 12);
        check_val("basic_hops", hops_from_ch, 1);
        check_val("basic_done_delay", done_cyc - last_en_cyc, SETTLE + 1);
        check_val("basic_timeout_flag", done_to, 0);
        check_val("basic_kch_id_hold", kch_id, 12);
        tick();
        check_val("basic_done_one_cycle", ch_done, 0);
        check_val("basic_idle", busy, 0);

        // Backpressure: six back-to-back advertisements into a 4-deep FIFO.
        start_round(16'd6);
        saw_stall = 1'b0;
        for (int i = 0; i < 6; i++)
            offer(W'($urandom_range(0, 65535)), W'($urandom_range(0, 15)), W'($urandom_range(0, 65535)));
        wait_done(100);
        check_val("bp_stall_seen", saw_stall, 1);
        check_val("bp_pops", en_cnt, 6);
        check_val("bp_ch_count", ch_count, 6);
        check_result("bp");

        // Abort after one pop of a limit-3 round.
        start_round(16'd3);
        offer(16'd101, 16'd3, 16'h1111);
        offer(16'd102, 16'd3, 16'h7777);
        offer(16'd103, 16'd3, 16'h2222);
        wait_pops(1, 40);
        prev_chosen  = chosen_ch;
        dones_before = done_total;
        start_round(16'd2);
        check_val("abort_clear_burst", kch_hb_reset, 1);
        check_val("abort_ch_count", ch_count, 0);
        check_val("abort_chosen_kept", chosen_ch, prev_chosen);
        offer(16'd201, 16'd4, 16'h0100);
        offer(16'd202, 16'd5, 16'h0500);
        wait_done(60);
        check_val("abort_done_count", done_total - dones_before, 1);
        check_val("abort_clr_len", clr_len, 2);
        check_val("abort_pops", en_cnt, 2);
        check_result("abort");

        // Zero limit: straight from CLEAR to DONE.
        start_round(16'd0);
        wait_done(20);
        check_val("zero_latency", done_cyc - hb_cyc, 3);
        check_val("zero_pops", en_cnt, 0);
        check_val("zero_chosen", chosen_ch, 0);
        check_val("zero_hops", hops_from_ch, 16'hFFFF);

        // Randomized rounds with gappy valid and surplus advertisements.
        gappy = 1'b1;
        for (int r = 0; r < 4; r++) begin
            lim  = $urandom_range(1, 5);
            nadv = lim + $urandom_range(0, 2);
            start_round(W'(lim));
            for (int i = 0; i < nadv; i++)
                offer(W'($urandom_range(0, 65535)), W'($urandom_range(0, 15)), W'($urandom_range(0, 65535)));
            wait_done(300);
            check_val("rnd_pops", en_cnt, lim);
            check_val("rnd_ch_count", ch_count, lim);
            check_val("rnd_timeout_flag", done_to, 0);
            check_result("rnd");
        end
        gappy = 1'b0;

        // Asynchronous reset in the middle of a round.
        start_round(16'd4);
        for (int i = 0; i < 4; i++) offer(W'(300 + i), 16'd2, W'(16'h1000 + i));
        wait_pops(1, 40);
        #2;
        rst = 1'b1;
        #1;
        check_val("async_rst_busy", busy, 0);
        check_val("async_rst_ch_count", ch_count, 0);
        check_val("async_rst_kch_hops", kch_hops, 16'hFFFF);
        check_val("async_rst_adv_ready", adv_ready, 0);
        offer_q.delete(); model_q.delete(); adv_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick(); tick();
        check_val("async_rst_no_done", done_seen, 0);

        // Inactivity timeout: one advertisement for a limit-2 round.
        start_round(16'd2);
        repeat (5) tick();
        offer(16'd65, 16'd1, 16'h6000);
        wait_pops(1, 20);
        check_val("accept_to_en", last_en_cyc - acc_cyc, 1);
`ifdef KCH_TIMEOUT_EN
        wait_done(60);
        check_val("to_delay", done_cyc - last_en_cyc, TMO);
        check_val("to_flag", done_to, 1);
        check_val("to_chosen", chosen_ch, 65);
        check_val("to_hops", hops_from_ch, 1);
`else
        for (int i = 0; i < 100 && !done_seen; i++) tick();
        check_val("no_to_done", done_seen, 0);
        check_val("no_to_busy", busy, 1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/kch_sequencer.md
# kch_sequencer

Round controller for the known-cluster-head (known-CH) tracker. When a heartbeat arrives, it clears the tracker and buffers incoming CH advertisements in a small FIFO. It replays them one at a time as single-cycle tracker enables, spaced by a settle window, until the heartbeat's CH limit is reached. It then latches the tracker's chosen CH and hop count and signals round completion to the node FSM.

## Interface
- WORD_WIDTH, 16, width of ID / hops / Q-value words
- FIFO_DEPTH, 4, advertisement buffer depth (power of 2, ≥2)
- CLR_CYCLES, 2, cycles the tracker clear is held high
- SETTLE_CYCLES, 2, idle cycles after each tracker enable before the next pop
- TIMEOUT, 1024, COLLECT inactivity limit in cycles (used only with KCH_TIMEOUT_EN)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- hb_start  in  1  one-cycle pulse: heartbeat received, start a new round
- hb_chlimit  in  WORD_WIDTH  number of CHs to collect; sampled when hb_start=1
- adv_valid  in  1  advertisement present
- adv_ready  out  1  advertisement accepted on an edge where valid&ready
- adv_id / adv_hops / adv_qvalue  in  WORD_WIDTH each  advertised CH ID, hops, Q-value
- kch_hb_reset  out  1  tracker clear
- kch_en  out  1  tracker update strobe
- kch_id / kch_hops / kch_qvalue  out  WORD_WIDTH each  data to tracker; valid while kch_en=1
- kch_chosen / kch_hopsfrom  in  WORD_WIDTH each  tracker's current best CH and hop count
- chosen_ch / hops_from_ch  out  WORD_WIDTH each  latched round result
- ch_done  out  1  one-cycle pulse: round complete, result valid
- ch_timeout  out  1  one-cycle pulse coincident with ch_done when the round ended by timeout
- ch_count  out  WORD_WIDTH  advertisements forwarded this round
- busy  out  1  high in any state other than IDLE

## Operation
- The state machine has four states: IDLE, CLEAR, COLLECT, DONE.
- IDLE
  - adv_ready=0.
  - hb_start → CLEAR.
- Entering CLEAR:
  - FIFO is flushed.
  - ch_count=0.
  - hb_chlimit is latched into a limit register.
  - Clear counter is loaded.
- CLEAR
  - kch_hb_reset=1 for exactly CLR_CYCLES cycles.
  - Then → COLLECT, or → DONE directly if limit=0.
- adv_ready = !fifo_full in CLEAR and COLLECT; 0 otherwise.
  - Full is the registered flag: a pop in the same cycle does not enable a push into a full FIFO.
  - Push and pop in the same cycle on a non-full, non-empty FIFO are both performed.
- COLLECT, pop rule:
  - Pop when the FIFO is non-empty, the settle counter is 0, and ch_count < limit.
  - On a pop, kch_id/hops/qvalue are registered from the FIFO head, kch_en=1 for one cycle, ch_count increments, and the settle counter is loaded with SETTLE_CYCLES.
- COLLECT → DONE when ch_count == limit and the settle counter has reached 0.
- DONE (one cycle):
  - chosen_ch←kch_chosen and hops_from_ch←kch_hopsfrom.
  - ch_done=1, then → IDLE.
  - Advertisements still in the FIFO are discarded at the next CLEAR.
- hb_start in CLEAR, COLLECT or DONE aborts the round and re-enters CLEAR as from IDLE (flush, new limit).
  - No ch_done is issued for the aborted round.
  - chosen_ch is unchanged.
- Width rules:
  - ch_count saturates at all-ones.
  - limit is unsigned.
  - The FIFO stores the three words (3×WORD_WIDTH) per entry.

## Timing
- Reset values:
  - All 1-bit outputs 0.
  - kch_id, kch_qvalue, chosen_ch, ch_count = 0.
  - kch_hops and hops_from_ch = all-ones (0xFFFF).
  - State = IDLE, FIFO empty, all counters 0.
- Reset is asynchronous. Asserted mid-round, it returns the block to IDLE immediately with no ch_done.
- hb_start sampled at edge T: kch_hb_reset is high in cycles T+1 … T+CLR_CYCLES.
- Advertisement accepted at edge A into an empty FIFO in COLLECT with settle=0: kch_en is high in cycle A+1 (output registered).
- Back-to-back pops are separated by at least SETTLE_CYCLES cycles with kch_en=0.
- Last pop at cycle P: ch_done pulses in cycle P+SETTLE_CYCLES+1, with chosen_ch valid from that cycle onward.
- kch_data outputs hold their last value between pops.

## Configuration
- KCH_TIMEOUT_EN defined:
  - A counter runs in COLLECT, cleared on each pop.
  - If it reaches TIMEOUT while ch_count < limit, the block → DONE, with ch_timeout=1 in the same cycle as ch_done.
  - The result is latched from the tracker as normal (with zero pops it is the cleared tracker value).
- KCH_TIMEOUT_EN undefined:
  - No counter is built and ch_timeout is tied 0.
  - COLLECT waits indefinitely for hb_chlimit advertisements.

## Test plan
- Reset: after rst pulse → busy=0, adv_ready=0, kch_hops=hops_from_ch=0xFFFF, ch_done=0.
- hb_start with limit 3, then advertisements (23,2,0x3000), (45,2,0x2000), (12,1,0x4000) arriving back-to-back:
  - kch_hb_reset high 2 cycles.
  - kch_en pulses 3 times, each ≥3 cycles apart.
  - ch_count=3.
  - ch_done with chosen_ch=12, hops_from_ch=1.
- Backpressure: FIFO_DEPTH=4, 6 advertisements offered continuously with limit 6 → adv_ready drops while full, none lost, 6 kch_en pulses in arrival order.
- Abort: hb_start again after 1 pop of a limit-3 round → FIFO flushed, second kch_hb_reset burst, ch_count=0, no ch_done until the new round completes.
- Zero limit: hb_start with limit 0 → ch_done 3 cycles after hb_start (CLR_CYCLES+1), kch_en never asserted.
- With KCH_TIMEOUT_EN and TIMEOUT=16: limit 2, one advertisement (65,1,0x6000) → ch_done and ch_timeout pulse together 16 cycles after the pop, chosen_ch=65; without the macro → no ch_done within 100 cycles.
